// File: rtl/board_status_display_pkg.sv
// rtl/board_status_display_pkg.sv - shared constants for the board status display
// Contents: 7-segment table (active-low, bit6 = g), blank pattern, count width.
package board_status_display_pkg;

    localparam int CNT_W = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/board_status_display_if.sv
// rtl/board_status_display_if.sv - game-to-display board state bundle
// Signals: cursorGrid (one-hot cursor), revealGrid (revealed cells),
//          states (4 bits per cell), wl (win/lose flags).
// Modports: master = game side (drives), slave = display side (samples).
interface board_status_display_if #(
    parameter int N = 9
);
    logic [N-1:0]   cursorGrid;
    logic [N-1:0]   revealGrid;
    logic [4*N-1:0] states;
    logic [1:0]     wl;

    modport master (output cursorGrid, output revealGrid, output states, output wl);
    modport slave  (input  cursorGrid, input  revealGrid, input  states, input  wl);
endinterface

// File: rtl/board_status_display_seg7_decode.sv
// rtl/board_status_display_seg7_decode.sv - hex nibble to active-low 7-segment decoder
// Ports: val_i (4-bit nibble), seg_o (7-bit active-low segments, bit6 = g).
module seg7_decode
    import board_status_display_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_TABLE[val_i];
endmodule

// File: rtl/board_status_display.sv
// rtl/board_status_display.sv - cursor cell display with blink, reveal counter scan
// Ports: clock, reset (async active-low), game (board bundle, slave),
//        hex_cur / hex_cnt_lo / hex_cnt_hi (active-low segments),
//        reveal_count, scan_done, cursor_err, game_over.
module board_status_display
    import board_status_display_pkg::*;
#(
    parameter int ROWS      = 3,
    parameter int COLS      = 3,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    board_status_display_if.slave game,
    output logic [6:0]            hex_cur,
    output logic [6:0]            hex_cnt_lo,
    output logic [6:0]            hex_cnt_hi,
    output logic [CNT_W-1:0]      reveal_count,
    output logic                  scan_done,
    output logic                  cursor_err,
    output logic                  game_over
);
    localparam int N  = ROWS * COLS;
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(N - 1);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);

    generate
        if (N < 1 || N > 255 || BLINK_DIV < 2) begin : g_bad_param
            $error("board_status_display: need 1 <= ROWS*COLS <= 255 and BLINK_DIV >= 2");
        end
    endgenerate

    // Cursor select: descending loop so the lowest set index wins.
    logic [3:0] sel_state_d, sel_state_q;
    logic       sel_rev_d, sel_rev_q;
    logic       cursor_err_d, cursor_err_q;

    always_comb begin
        sel_state_d = '0;
        sel_rev_d   = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (game.cursorGrid[i]) begin
                sel_state_d = game.states[4*i +: 4];
                sel_rev_d   = game.revealGrid[i];
            end
        end
        cursor_err_d = (game.cursorGrid == '0) ||
                       ((game.cursorGrid & (game.cursorGrid - N'(1))) != '0);
    end

    // Blink: game_over uses the live flag so the phase is already 0 on the
    // first cycle game_over_q reads 1.
    logic [BW-1:0] blink_cnt_d, blink_cnt_q;
    logic          phase_d, phase_q;
    logic          game_over_d, game_over_q;

    always_comb begin
        game_over_d = |game.wl;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (game_over_d) begin
            phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    // Reveal scan: padded copy lets an 8-bit index address any legal N.
    logic [255:0]     rev_pad;
    logic [CNT_W-1:0] scan_idx_d, scan_idx_q;
    logic [CNT_W-1:0] acc_d, acc_q, acc_plus;
    logic [CNT_W-1:0] reveal_count_d, reveal_count_q;
    logic             scan_done_d, scan_done_q;

    assign rev_pad  = 256'(game.revealGrid);
    assign acc_plus = acc_q + CNT_W'(rev_pad[scan_idx_q]);

    always_comb begin
        scan_idx_d     = scan_idx_q + CNT_W'(1);
        acc_d          = acc_plus;
        reveal_count_d = reveal_count_q;
        scan_done_d    = 1'b0;
        if (scan_idx_q == LAST_IDX) begin
            scan_idx_d     = '0;
            acc_d          = '0;
            reveal_count_d = acc_plus;
            scan_done_d    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_state_q    <= '0;
            sel_rev_q      <= 1'b1;
            cursor_err_q   <= 1'b0;
            blink_cnt_q    <= '0;
            phase_q        <= 1'b0;
            game_over_q    <= 1'b0;
            scan_idx_q     <= '0;
            acc_q          <= '0;
            reveal_count_q <= '0;
            scan_done_q    <= 1'b0;
        end else begin
            sel_state_q    <= sel_state_d;
            sel_rev_q      <= sel_rev_d;
            cursor_err_q   <= cursor_err_d;
            blink_cnt_q    <= blink_cnt_d;
            phase_q        <= phase_d;
            game_over_q    <= game_over_d;
            scan_idx_q     <= scan_idx_d;
            acc_q          <= acc_d;
            reveal_count_q <= reveal_count_d;
            scan_done_q    <= scan_done_d;
        end
    end

    logic [6:0] cur_seg;

    seg7_decode u_dec_cur (.val_i(sel_state_q),         .seg_o(cur_seg));
    seg7_decode u_dec_lo  (.val_i(reveal_count_q[3:0]), .seg_o(hex_cnt_lo));
    seg7_decode u_dec_hi  (.val_i(reveal_count_q[7:4]), .seg_o(hex_cnt_hi));

    assign hex_cur      = (!sel_rev_q && phase_q) ? SEG_BLANK : cur_seg;
    assign reveal_count = reveal_count_q;
    assign scan_done    = scan_done_q;
    assign cursor_err   = cursor_err_q;
    assign game_over    = game_over_q;

endmodule
